// File: rtl/exc_ctrl.sv
// exc_ctrl -- MEM-stage exception / interrupt commit controller.
//
// Picks the highest-priority event raised by the MEM-stage instruction
// (synchronised interrupt, address errors, overflow, syscall, break,
// reserved instruction, ERET), commits at most one per cycle, and then
// holds the pipeline in FLUSH until the front end acknowledges the redirect.
//
// Optional feature: define EXC_DELAYSLOT_EN to add exc_bd_i / exc_bd_o.
// Then EPC is rewound to the branch (pc-4) for events in a delay slot.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   exc_valid_i     MEM-stage instruction valid
//   exc_pc_i        MEM-stage PC
//   exc_mem_en_i    memory request in flight (blocks interrupts)
//   exc_m_addr_i    data address of the MEM-stage access
//   exc_excs_i      exception flags [0]AdEL_if [1]AdEL_ld [2]AdES [3]Ov
//                   [4]SysC [5]Bp [6]RI [7]ERET
//   exc_epc_i       current CP0 EPC (ERET return target)
//   int_i           raw asynchronous interrupt lines
//   int_mask_i      Status.IM
//   int_ie_i        interrupts globally enabled
//   flush_ack_i     front end accepted the flush target
//   exc_flag_o      commit pulse
//   exc_code_o      ExcCode of the committed event
//   exc_eret_o      commit pulse for ERET
//   exc_epc_o       EPC value for CP0
//   exc_baddr_o     BadVAddr value
//   exc_baddr_we_o  BadVAddr write pulse
//   flush_req_o     flush request
//   flush_pc_o      redirect target
//   stall_o         pipeline hold while the flush is outstanding
//   int_pending_o   synchronised, masked interrupt lines (Cause.IP)
//   exc_bd_i/o      delay-slot flag in / committed (EXC_DELAYSLOT_EN only)
module exc_ctrl #(
  parameter int          NUM_INT     = 6,
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               exc_valid_i,
  input  logic [31:0]        exc_pc_i,
  input  logic               exc_mem_en_i,
  input  logic [31:0]        exc_m_addr_i,
  input  logic [7:0]         exc_excs_i,
  input  logic [31:0]        exc_epc_i,
  input  logic [NUM_INT-1:0] int_i,
  input  logic [NUM_INT-1:0] int_mask_i,
  input  logic               int_ie_i,
  input  logic               flush_ack_i,
`ifdef EXC_DELAYSLOT_EN
  input  logic               exc_bd_i,
  output logic               exc_bd_o,
`endif
  output logic               exc_flag_o,
  output logic [4:0]         exc_code_o,
  output logic               exc_eret_o,
  output logic [31:0]        exc_epc_o,
  output logic [31:0]        exc_baddr_o,
  output logic               exc_baddr_we_o,
  output logic               flush_req_o,
  output logic [31:0]        flush_pc_o,
  output logic               stall_o,
  output logic [NUM_INT-1:0] int_pending_o
);

  typedef enum logic {ST_IDLE, ST_FLUSH} state_t;

  state_t                              r_state;
  logic [SYNC_STAGES-1:0][NUM_INT-1:0] r_sync;
  logic                                r_flag;
  logic [4:0]                          r_code;
  logic                                r_eret;
  logic [31:0]                         r_epc;
  logic [31:0]                         r_baddr;
  logic                                r_baddr_we;
  logic                                r_flush_req;
  logic [31:0]                         r_flush_pc;
  logic                                r_bd;

  logic        w_int_req;
  logic        w_hit;
  logic        w_commit;
  logic [4:0]  w_code;
  logic        w_eret;
  logic        w_baddr_we;
  logic [31:0] w_baddr;
  logic [31:0] w_epc;
  logic        w_bd;

  // Interrupt synchroniser: int_i is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= int_i;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign int_pending_o = r_sync[SYNC_STAGES-1] & int_mask_i;

  // Interrupts are not taken while a memory access is in flight so the
  // access is never replayed after it already had side effects.
  assign w_int_req = (|int_pending_o) & int_ie_i & exc_valid_i & ~exc_mem_en_i;

  // Fixed-priority event selection.
  always_comb begin
    w_hit      = 1'b0;
    w_code     = 5'd0;
    w_eret     = 1'b0;
    w_baddr_we = 1'b0;
    w_baddr    = 32'd0;
    if (w_int_req) begin
      w_hit = 1'b1;
    end else if (exc_excs_i[0]) begin
      w_hit = 1'b1; w_code = 5'd4; w_baddr_we = 1'b1; w_baddr = exc_pc_i;
    end else if (exc_excs_i[1]) begin
      w_hit = 1'b1; w_code = 5'd4; w_baddr_we = 1'b1; w_baddr = exc_m_addr_i;
    end else if (exc_excs_i[2]) begin
      w_hit = 1'b1; w_code = 5'd5; w_baddr_we = 1'b1; w_baddr = exc_m_addr_i;
    end else if (exc_excs_i[3]) begin
      w_hit = 1'b1; w_code = 5'd12;
    end else if (exc_excs_i[4]) begin
      w_hit = 1'b1; w_code = 5'd8;
    end else if (exc_excs_i[5]) begin
      w_hit = 1'b1; w_code = 5'd9;
    end else if (exc_excs_i[6]) begin
      w_hit = 1'b1; w_code = 5'd10;
    end else if (exc_excs_i[7]) begin
      w_hit = 1'b1; w_eret = 1'b1;
    end
  end

  assign w_commit = w_hit & exc_valid_i & (r_state == ST_IDLE);

`ifdef EXC_DELAYSLOT_EN
  // A delay-slot instruction restarts at its branch.
  assign w_bd  = exc_bd_i & ~w_eret;
  assign w_epc = w_bd ? (exc_pc_i - 32'd4) : exc_pc_i;
  assign exc_bd_o = r_bd;
`else
  assign w_bd  = 1'b0;
  assign w_epc = exc_pc_i;
`endif

  // Commit FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_flag      <= 1'b0;
      r_code      <= 5'd0;
      r_eret      <= 1'b0;
      r_epc       <= 32'd0;
      r_baddr     <= 32'd0;
      r_baddr_we  <= 1'b0;
      r_flush_req <= 1'b0;
      r_flush_pc  <= 32'd0;
      r_bd        <= 1'b0;
    end else begin
      r_flag     <= 1'b0;
      r_eret     <= 1'b0;
      r_baddr_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_commit) begin
            r_state     <= ST_FLUSH;
            r_flag      <= 1'b1;
            r_eret      <= w_eret;
            r_code      <= w_code;
            r_baddr     <= w_baddr;
            r_baddr_we  <= w_baddr_we;
            r_flush_req <= 1'b1;
            r_flush_pc  <= w_eret ? exc_epc_i : EXC_VECTOR;
            r_bd        <= w_bd;
            if (!w_eret) r_epc <= w_epc;
          end
        end
        ST_FLUSH: begin
          // Any event presented alongside the ack is re-evaluated next cycle.
          if (flush_ack_i) begin
            r_state     <= ST_IDLE;
            r_flush_req <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign exc_flag_o     = r_flag;
  assign exc_code_o     = r_code;
  assign exc_eret_o     = r_eret;
  assign exc_epc_o      = r_epc;
  assign exc_baddr_o    = r_baddr;
  assign exc_baddr_we_o = r_baddr_we;
  assign flush_req_o    = r_flush_req;
  assign flush_pc_o     = r_flush_pc;
  assign stall_o        = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_exc_ctrl.sv
module tb_exc_ctrl;
  localparam int          NI  = 6;
  localparam int          SS  = 2;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic          clk = 1'b0;
  logic          rst;
  logic          exc_valid_i, exc_mem_en_i, int_ie_i, flush_ack_i;
  logic [31:0]   exc_pc_i, exc_m_addr_i, exc_epc_i;
  logic [7:0]    exc_excs_i;
  logic [NI-1:0] int_i, int_mask_i;
  logic          exc_flag_o, exc_eret_o, exc_baddr_we_o, flush_req_o, stall_o;
  logic [4:0]    exc_code_o;
  logic [31:0]   exc_epc_o, exc_baddr_o, flush_pc_o;
  logic [NI-1:0] int_pending_o;
`ifdef EXC_DELAYSLOT_EN
  logic          exc_bd_i, exc_bd_o;
`endif

  exc_ctrl #(.NUM_INT(NI), .EXC_VECTOR(VEC), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst),
    .exc_valid_i(exc_valid_i), .exc_pc_i(exc_pc_i), .exc_mem_en_i(exc_mem_en_i),
    .exc_m_addr_i(exc_m_addr_i), .exc_excs_i(exc_excs_i), .exc_epc_i(exc_epc_i),
    .int_i(int_i), .int_mask_i(int_mask_i), .int_ie_i(int_ie_i),
    .flush_ack_i(flush_ack_i),
`ifdef EXC_DELAYSLOT_EN
    .exc_bd_i(exc_bd_i), .exc_bd_o(exc_bd_o),
`endif
    .exc_flag_o(exc_flag_o), .exc_code_o(exc_code_o), .exc_eret_o(exc_eret_o),
    .exc_epc_o(exc_epc_o), .exc_baddr_o(exc_baddr_o), .exc_baddr_we_o(exc_baddr_we_o),
    .flush_req_o(flush_req_o), .flush_pc_o(flush_pc_o), .stall_o(stall_o),
    .int_pending_o(int_pending_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ExcCode per flag bit, priority = lowest bit first.
  int            CODES [8] = '{4, 4, 5, 12, 8, 9, 10, 0};
  logic [NI-1:0] m_hist [SS];   // int_i samples, [0] = most recent edge
  logic          m_busy, m_flag, m_eret, m_bwe, m_bd;
  logic [4:0]    m_code;
  logic [31:0]   m_epc, m_baddr, m_fpc;

  task automatic model_reset();
    for (int k = 0; k < SS; k++) m_hist[k] = '0;
    m_busy = 0; m_flag = 0; m_eret = 0; m_bwe = 0; m_bd = 0;
    m_code = 0; m_epc = 0; m_baddr = 0; m_fpc = 0;
  endtask

  task automatic model_edge();
    logic [NI-1:0] pend;
    logic          bd_in;
    int            ev;
    pend  = m_hist[SS-1] & int_mask_i;
`ifdef EXC_DELAYSLOT_EN
    bd_in = exc_bd_i;
`else
    bd_in = 1'b0;
`endif
    m_flag = 0; m_eret = 0; m_bwe = 0;
    if (m_busy) begin
      if (flush_ack_i) m_busy = 0;
    end else if (exc_valid_i) begin
      ev = -1;
      for (int b = 7; b >= 0; b--) if (exc_excs_i[b]) ev = b;
      if ((|pend) && int_ie_i && !exc_mem_en_i) ev = 8;
      if (ev >= 0) begin
        m_busy  = 1;
        m_flag  = 1;
        m_code  = (ev == 8) ? 5'd0 : 5'(CODES[ev]);
        m_eret  = (ev == 7);
        m_bwe   = (ev <= 2);
        m_baddr = (ev == 0) ? exc_pc_i : (ev == 1 || ev == 2) ? exc_m_addr_i : 32'd0;
        if (ev == 7) begin
          m_fpc = exc_epc_i;
          m_bd  = 0;
        end else begin
          m_fpc = VEC;
          m_bd  = bd_in;
          m_epc = bd_in ? exc_pc_i - 32'd4 : exc_pc_i;
        end
      end
    end
    for (int k = SS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = int_i;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("flag",     32'(exc_flag_o),     32'(m_flag));
    chk("code",     32'(exc_code_o),     32'(m_code));
    chk("eret",     32'(exc_eret_o),     32'(m_eret));
    chk("epc",      exc_epc_o,           m_epc);
    chk("baddr",    exc_baddr_o,         m_baddr);
    chk("baddr_we", 32'(exc_baddr_we_o), 32'(m_bwe));
    chk("flush_req",32'(flush_req_o),    32'(m_busy));
    chk("flush_pc", flush_pc_o,          m_fpc);
    chk("stall",    32'(stall_o),        32'(m_busy));
    chk("pending",  32'(int_pending_o),  32'(m_hist[SS-1] & int_mask_i));
`ifdef EXC_DELAYSLOT_EN
    chk("bd",       32'(exc_bd_o),       32'(m_bd));
`endif
  endtask

  // One clock: model consumes the inputs present before the edge.
  task automatic tick();
    if (rst) model_reset(); else model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    exc_valid_i = 0; exc_pc_i = 0; exc_mem_en_i = 0; exc_m_addr_i = 0;
    exc_excs_i = 0; exc_epc_i = 0; int_i = 0; int_mask_i = 0; int_ie_i = 0;
    flush_ack_i = 0;
`ifdef EXC_DELAYSLOT_EN
    exc_bd_i = 0;
`endif
  endtask

  task automatic release_flush();
    exc_valid_i = 0; flush_ack_i = 1; tick(); flush_ack_i = 0;
  endtask

  // Asynchronous reset applied between edges.
  task automatic async_reset();
    rst = 1;
    #1;
    model_reset();
    chk("rst_flush_req", 32'(flush_req_o), 32'd0);
    chk("rst_stall",     32'(stall_o),     32'd0);
    chk("rst_flush_pc",  flush_pc_o,       32'd0);
    tick();
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int stall_cnt;
    idle_inputs();
    rst = 1;
    model_reset();
    tick(); tick();
    chk("reset_flag", 32'(exc_flag_o), 32'd0);
    chk("reset_stall", 32'(stall_o), 32'd0);
    rst = 0;
    tick();

    // Ov and SysC together: Ov wins.
    exc_valid_i = 1; exc_pc_i = 32'h8000_0100; exc_excs_i = 8'h18;
    tick();
    chk("ov_code", 32'(exc_code_o), 32'd12);
    chk("ov_epc", exc_epc_o, 32'h8000_0100);
    chk("ov_fpc", flush_pc_o, 32'hBFC0_0380);
    release_flush();

    // AdES stores the data address with a single-cycle strobe.
    exc_valid_i = 1; exc_excs_i = 8'h04; exc_m_addr_i = 32'h8000_0003;
    tick();
    chk("ades_code", 32'(exc_code_o), 32'd5);
    chk("ades_baddr", exc_baddr_o, 32'h8000_0003);
    chk("ades_we", 32'(exc_baddr_we_o), 32'd1);
    release_flush();
    chk("ades_we_drop", 32'(exc_baddr_we_o), 32'd0);

    // Interrupt latency through the synchroniser.
    exc_valid_i = 1; exc_excs_i = 0; int_i = 6'h04; int_mask_i = 6'h04; int_ie_i = 1;
    for (int i = 0; i < SS; i++) tick();
    chk("int_early", 32'(exc_flag_o), 32'd0);
    tick();
    chk("int_flag", 32'(exc_flag_o), 32'd1);
    chk("int_code", 32'(exc_code_o), 32'd0);
    exc_mem_en_i = 1; flush_ack_i = 1; tick(); flush_ack_i = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("int_memen_blocked", 32'(stall_o), 32'd0);
    int_i = 0; int_mask_i = 0; exc_mem_en_i = 0; exc_valid_i = 0;
    for (int i = 0; i < SS + 1; i++) tick();

    // ERET, delayed ack, RI ignored while flushing, ack wins over RI.
    exc_valid_i = 1; exc_excs_i = 8'h80; exc_epc_i = 32'h8000_2000;
    tick();
    chk("eret_pulse", 32'(exc_eret_o), 32'd1);
    chk("eret_fpc", flush_pc_o, 32'h8000_2000);
    stall_cnt = int'(stall_o);
    exc_excs_i = 8'h40;
    tick(); stall_cnt += int'(stall_o);
    tick(); stall_cnt += int'(stall_o);
    chk("eret_ri_ignored", 32'(exc_flag_o), 32'd0);
    flush_ack_i = 1; tick(); stall_cnt += int'(stall_o);
    chk("eret_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("ack_wins", 32'(exc_flag_o), 32'd0);
    flush_ack_i = 0; tick();
    chk("ri_after_ack", 32'(exc_code_o), 32'd10);
    release_flush();

    // Reset in the middle of a flush.
    exc_valid_i = 1; exc_excs_i = 8'h20; exc_pc_i = 32'h8000_0040;
    tick();
    exc_valid_i = 0;
    async_reset();
    tick();
    chk("post_rst_idle", 32'(stall_o), 32'd0);

`ifdef EXC_DELAYSLOT_EN
    exc_valid_i = 1; exc_excs_i = 8'h20; exc_pc_i = 32'h0; exc_bd_i = 1;
    tick();
    chk("bd_epc", exc_epc_o, 32'hFFFF_FFFC);
    chk("bd_flag", 32'(exc_bd_o), 32'd1);
    exc_bd_i = 0;
    release_flush();
`endif

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      exc_valid_i  = ($urandom_range(0, 3) != 0);
      exc_pc_i     = $urandom & 32'hFFFF_FFFC;
      exc_m_addr_i = $urandom;
      exc_excs_i   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      exc_epc_i    = $urandom;
      exc_mem_en_i = ($urandom_range(0, 2) == 0);
      int_ie_i     = ($urandom_range(0, 1) == 1);
      int_mask_i   = NI'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) int_i = NI'($urandom_range(0, 63));
      flush_ack_i  = ($urandom_range(0, 2) == 0);
`ifdef EXC_DELAYSLOT_EN
      exc_bd_i     = ($urandom_range(0, 1) == 1);
`endif
      if ($urandom_range(0, 199) == 0) async_reset();
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter NUM_INT, default 6, number of hardware interrupt lines (1..8).
REQ-002 SHALL have parameter EXC_VECTOR, default 32'hBFC0_0380, general exception entry address.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, interrupt synchroniser depth (1..3).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 exc_valid_i  in  1  MEM-stage instruction valid.
REQ-007 exc_pc_i  in  32  PC of MEM-stage instruction.
REQ-008 exc_mem_en_i  in  1  MEM-stage instruction has a memory request in flight.
REQ-009 exc_m_addr_i  in  32  data address of MEM-stage access.
REQ-010 exc_excs_i  in  8  flags [0]AdEL_if [1]AdEL_ld [2]AdES [3]Ov [4]SysC [5]Bp [6]RI [7]ERET.
REQ-011 exc_epc_i  in  32  current CP0 EPC.
REQ-012 int_i  in  NUM_INT  raw asynchronous interrupt lines.
REQ-013 int_mask_i  in  NUM_INT  CP0 Status.IM.
REQ-014 int_ie_i  in  1  interrupts globally enabled (Status.IE & ~EXL).
REQ-015 flush_ack_i  in  1  front end accepted flush target.
REQ-016 exc_flag_o  out  1  one-cycle pulse, exception/interrupt/ERET committed.
REQ-017 exc_code_o  out  5  MIPS ExcCode of committed event.
REQ-018 exc_eret_o  out  1  one-cycle pulse, committed event is ERET.
REQ-019 exc_epc_o  out  32  EPC value for CP0 write.
REQ-020 exc_baddr_o  out  32  BadVAddr value; exc_baddr_we_o  out  1  BadVAddr write strobe (pulse).
REQ-021 flush_req_o  out  1  flush request; flush_pc_o  out  32  redirect target.
REQ-022 stall_o  out  1  hold pipeline while flush outstanding.
REQ-023 int_pending_o  out  NUM_INT  synchronised, masked interrupt lines (CP0 Cause.IP).

Function
REQ-024 int_i SHALL pass through SYNC_STAGES flops; int_pending_o = synchronised & int_mask_i.
REQ-025 Interrupt request SHALL be |int_pending_o & int_ie_i & exc_valid_i & ~exc_mem_en_i.
REQ-026 Events SHALL be considered only when exc_valid_i=1 and state IDLE.
REQ-027 Priority SHALL be Int > AdEL_if > AdEL_ld > AdES > Ov > SysC > Bp > RI > ERET; one event committed per cycle.
REQ-028 ExcCode SHALL be Int 0, AdEL 4, AdES 5, SysC 8, Bp 9, RI 10, Ov 12; ERET leaves exc_code_o at 0.
REQ-029 FSM states IDLE, FLUSH; IDLE->FLUSH on committed event; FLUSH->IDLE on cycle with flush_ack_i=1.
REQ-030 Latency: event in cycle N SHALL produce registered exc_flag_o, flush_req_o, outputs in N+1.
REQ-031 flush_pc_o SHALL be EXC_VECTOR for exceptions/interrupts, exc_epc_i (latched at N) for ERET; held stable through FLUSH.
REQ-032 exc_baddr_o SHALL be exc_pc_i for AdEL_if, exc_m_addr_i for AdEL_ld/AdES, with exc_baddr_we_o pulse; else 0, no strobe.
REQ-033 exc_epc_o SHALL be exc_pc_i latched at N; not updated for ERET.
REQ-034 stall_o SHALL equal state==FLUSH; inputs in FLUSH ignored.
REQ-035 flush_ack_i in IDLE SHALL be ignored; ack and new event same cycle in FLUSH: ack wins, event evaluated next cycle.

Reset
REQ-036 rst SHALL clear state to IDLE, synchroniser flops to 0, all outputs to 0 (flush_pc_o 0) immediately.
REQ-037 rst asserted in FLUSH SHALL drop flush_req_o without ack; pending event discarded.

Configuration
REQ-038 Macro EXC_DELAYSLOT_EN defined: ports exc_bd_i (in 1) and exc_bd_o (out 1) exist; for non-ERET events with exc_bd_i=1, exc_epc_o = exc_pc_i-4 (mod 2^32) and exc_bd_o=1, else exc_bd_o=0.
REQ-039 Macro undefined: no delay-slot ports; exc_epc_o = exc_pc_i always.

Verification
REQ-040 Ov and SysC both set, pc 0x8000_0100 -> N+1 exc_code_o 12, exc_epc_o 0x8000_0100, flush_pc_o 0xBFC0_0380.
REQ-041 AdES, m_addr 0x8000_0003 -> exc_code_o 5, exc_baddr_o 0x8000_0003, exc_baddr_we_o pulse 1 cycle.
REQ-042 int_i[2]=1, mask 0x04, ie 1, mem_en 0 -> commit after SYNC_STAGES+1 cycles, exc_code_o 0; with mem_en 1 -> no commit.
REQ-043 ERET, exc_epc_i 0x8000_2000 -> exc_eret_o 1, flush_pc_o 0x8000_2000; ack delayed 3 cycles -> stall_o 3 cycles, RI during wait ignored.
REQ-044 rst mid-FLUSH -> flush_req_o, stall_o 0 immediately; state IDLE.
REQ-045 EXC_DELAYSLOT_EN, Bp with exc_bd_i=1, pc 0x0000_0000 -> exc_epc_o 0xFFFF_FFFC, exc_bd_o 1.
